// File: rtl/foc_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | foc_pkg: sequencer state encoding and counter-width helper         |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package foc_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADC   = 3'd1,
        S_PARK  = 3'd2,
        S_CTRL  = 3'd3,
        S_IPARK = 3'd4,
        S_LOAD  = 3'd5,
        S_FAULT = 3'd6
    } seq_state_t;

    localparam int PWM_DIV_MAX = 255;

    // Bits needed to hold 0..max_count-1 (at least one bit).
    function automatic int cnt_width(input int max_count);
        return (max_count < 2) ? 1 : $clog2(max_count);
    endfunction

endpackage
`default_nettype wire

// File: rtl/foc_loop_sequencer_decimator.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sync_decimator: emits tick on every PWM_DIV-th pwm_sync pulse      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module sync_decimator
    import foc_pkg::*;
#(
    parameter int PWM_DIV = 1
) (
    input  logic clk,
    input  logic nrst,
    input  logic run,
    input  logic pwm_sync,
    output logic tick
);

    localparam int            c_cnt_w = cnt_width(PWM_DIV);
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(PWM_DIV - 1);

    logic [c_cnt_w-1:0] cnt_q;
    logic [c_cnt_w-1:0] cnt_d;

    // Tick is combinational so the FSM starts on the edge that samples the sync.
    always_comb begin
        cnt_d = cnt_q;
        tick  = 1'b0;
        if (!run) begin
            cnt_d = '0;
        end else if (pwm_sync) begin
            if (cnt_q == c_last) begin
                tick  = 1'b1;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule
`default_nettype wire

// File: rtl/foc_loop_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | foc_loop_sequencer: per-PWM-period current-loop stage scheduler    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module foc_loop_sequencer
    import foc_pkg::*;
#(
    parameter int PWM_DIV  = 1,
    parameter int CTRL_LAT = 2,
    parameter int TIMEOUT  = 255,
    parameter int CW       = 16
) (
    input  logic          clk,
    input  logic          nrst,
    input  logic          run,
    input  logic          pwm_sync,
    output logic          adc_start,
    input  logic          adc_done,
    output logic          park_start,
    input  logic          park_done,
    output logic          ctrl_en,
    output logic          ipark_start,
    input  logic          ipark_done,
    output logic          pwm_load,
    output logic          busy,
    input  logic          fault_clr,
    output logic          timeout_err,
    output logic          overrun_err,
    output logic [CW-1:0] loop_cycles
);

    // One counter serves as both the watchdog and the CTRL latency timer.
    localparam int                 c_wd_max    = (TIMEOUT > CTRL_LAT) ? TIMEOUT : CTRL_LAT;
    localparam int                 c_wd_w      = cnt_width(c_wd_max);
    localparam logic [c_wd_w-1:0]  c_wd_last   = c_wd_w'(TIMEOUT - 1);
    localparam logic [c_wd_w-1:0]  c_ctrl_last = c_wd_w'(CTRL_LAT - 1);
    localparam logic [CW-1:0]      c_lat_max   = '1;

    logic w_tick;

    sync_decimator #(.PWM_DIV(PWM_DIV)) u_decimator (
        .clk      (clk),
        .nrst     (nrst),
        .run      (run),
        .pwm_sync (pwm_sync),
        .tick     (w_tick)
    );

    seq_state_t        state_q, state_d;
    logic [c_wd_w-1:0] wd_cnt_q, wd_cnt_d;
    logic [CW-1:0]     lat_cnt_q, lat_cnt_d;
    logic [CW-1:0]     loop_cycles_q, loop_cycles_d;
    logic adc_start_q, adc_start_d, park_start_q, park_start_d;
    logic ctrl_en_q, ctrl_en_d, ipark_start_q, ipark_start_d;
    logic pwm_load_q, pwm_load_d, busy_q, busy_d;
    logic timeout_err_q, timeout_err_d, overrun_err_q, overrun_err_d;
    logic w_busy, w_wd_exp, w_tmo_set, w_ovr_set;

    always_comb begin
        state_d       = state_q;
        wd_cnt_d      = '0;
        lat_cnt_d     = (lat_cnt_q == c_lat_max) ? lat_cnt_q : lat_cnt_q + 1'b1;
        loop_cycles_d = loop_cycles_q;
        adc_start_d   = 1'b0;
        park_start_d  = 1'b0;
        ctrl_en_d     = 1'b0;
        ipark_start_d = 1'b0;
        pwm_load_d    = 1'b0;
        w_tmo_set     = 1'b0;
        w_busy        = state_q inside {S_ADC, S_PARK, S_CTRL, S_IPARK, S_LOAD};
        w_wd_exp      = (wd_cnt_q == c_wd_last);
        w_ovr_set     = w_tick && w_busy;

        case (state_q)
            S_IDLE: begin
                if (w_tick && run) begin
                    state_d     = S_ADC;
                    adc_start_d = 1'b1;
                    lat_cnt_d   = CW'(1);
                end
            end
            S_ADC: begin
                if (adc_done) begin
                    state_d      = S_PARK;
                    park_start_d = 1'b1;
                end else if (w_wd_exp) begin
                    state_d   = S_FAULT;
                    w_tmo_set = 1'b1;
                end else begin
                    wd_cnt_d = wd_cnt_q + 1'b1;
                end
            end
            S_PARK: begin
                if (park_done) begin
                    state_d   = S_CTRL;
                    ctrl_en_d = 1'b1;
                end else if (w_wd_exp) begin
                    state_d   = S_FAULT;
                    w_tmo_set = 1'b1;
                end else begin
                    wd_cnt_d = wd_cnt_q + 1'b1;
                end
            end
            S_CTRL: begin
                if (wd_cnt_q == c_ctrl_last) begin
                    state_d       = S_IPARK;
                    ipark_start_d = 1'b1;
                end else begin
                    wd_cnt_d = wd_cnt_q + 1'b1;
                end
            end
            S_IPARK: begin
                if (ipark_done) begin
                    state_d       = S_LOAD;
                    pwm_load_d    = 1'b1;
                    loop_cycles_d = lat_cnt_d;
                end else if (w_wd_exp) begin
                    state_d   = S_FAULT;
                    w_tmo_set = 1'b1;
                end else begin
                    wd_cnt_d = wd_cnt_q + 1'b1;
                end
            end
            S_LOAD:  state_d = S_IDLE;
            S_FAULT: if (fault_clr) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Dropping run abandons the sequence outright: no load, no latency update.
        if (!run && w_busy) begin
            state_d       = S_IDLE;
            wd_cnt_d      = '0;
            loop_cycles_d = loop_cycles_q;
            adc_start_d   = 1'b0;
            park_start_d  = 1'b0;
            ctrl_en_d     = 1'b0;
            ipark_start_d = 1'b0;
            pwm_load_d    = 1'b0;
            w_tmo_set     = 1'b0;
        end

        timeout_err_d = w_tmo_set || (timeout_err_q && !fault_clr);
        overrun_err_d = w_ovr_set || (overrun_err_q && !fault_clr);
        busy_d        = state_d inside {S_ADC, S_PARK, S_CTRL, S_IPARK, S_LOAD};
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q       <= S_IDLE;
            wd_cnt_q      <= '0;
            lat_cnt_q     <= '0;
            loop_cycles_q <= '0;
            adc_start_q   <= 1'b0;
            park_start_q  <= 1'b0;
            ctrl_en_q     <= 1'b0;
            ipark_start_q <= 1'b0;
            pwm_load_q    <= 1'b0;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b0;
            overrun_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wd_cnt_q      <= wd_cnt_d;
            lat_cnt_q     <= lat_cnt_d;
            loop_cycles_q <= loop_cycles_d;
            adc_start_q   <= adc_start_d;
            park_start_q  <= park_start_d;
            ctrl_en_q     <= ctrl_en_d;
            ipark_start_q <= ipark_start_d;
            pwm_load_q    <= pwm_load_d;
            busy_q        <= busy_d;
            timeout_err_q <= timeout_err_d;
            overrun_err_q <= overrun_err_d;
        end
    end

    assign adc_start   = adc_start_q;
    assign park_start  = park_start_q;
    assign ctrl_en     = ctrl_en_q;
    assign ipark_start = ipark_start_q;
    assign pwm_load    = pwm_load_q;
    assign busy        = busy_q;
    assign timeout_err = timeout_err_q;
    assign overrun_err = overrun_err_q;
    assign loop_cycles = loop_cycles_q;

endmodule
`default_nettype wire

// File: tb/tb_foc_loop_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_foc_loop_sequencer: scoreboarded directed bench for sequencer   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_foc_loop_sequencer;

    typedef struct {
        int code;
        int cyc;
    } ev_t;

    logic        clk = 1'b0;
    logic        nrst, run, pwm_sync, adc_done, park_done, ipark_done, fault_clr;
    logic        adc_start, park_start, ctrl_en, ipark_start, pwm_load, busy;
    logic        timeout_err, overrun_err;
    logic [15:0] loop_cycles;

    logic        run3, sync3;
    logic        adc_start3, park_start3, ctrl_en3, ipark_start3, pwm_load3, busy3;
    logic        timeout_err3, overrun_err3;
    logic [15:0] loop_cycles3;

    int   cyc   = 0;
    int   tests = 0;
    int   fails = 0;
    int   n3    = 0;
    ev_t  exp_q[$];
    int   exp3[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    foc_loop_sequencer #(.PWM_DIV(1), .CTRL_LAT(2), .TIMEOUT(8), .CW(16)) dut (
        .clk(clk), .nrst(nrst), .run(run), .pwm_sync(pwm_sync),
        .adc_start(adc_start), .adc_done(adc_done),
        .park_start(park_start), .park_done(park_done),
        .ctrl_en(ctrl_en), .ipark_start(ipark_start), .ipark_done(ipark_done),
        .pwm_load(pwm_load), .busy(busy), .fault_clr(fault_clr),
        .timeout_err(timeout_err), .overrun_err(overrun_err),
        .loop_cycles(loop_cycles)
    );

    // Decimation instance: its datapath answers every start in the same cycle.
    foc_loop_sequencer #(.PWM_DIV(3), .CTRL_LAT(2), .TIMEOUT(8), .CW(16)) dut3 (
        .clk(clk), .nrst(nrst), .run(run3), .pwm_sync(sync3),
        .adc_start(adc_start3), .adc_done(adc_start3),
        .park_start(park_start3), .park_done(park_start3),
        .ctrl_en(ctrl_en3), .ipark_start(ipark_start3), .ipark_done(ipark_start3),
        .pwm_load(pwm_load3), .busy(busy3), .fault_clr(1'b0),
        .timeout_err(timeout_err3), .overrun_err(overrun_err3),
        .loop_cycles(loop_cycles3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic go_to(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_sig(input int sel, input logic v);
        case (sel)
            0:       pwm_sync   = v;
            1:       adc_done   = v;
            2:       park_done  = v;
            3:       ipark_done = v;
            default: fault_clr  = v;
        endcase
    endtask

    task automatic pulse(input int sel, input int c);
        go_to(c);
        set_sig(sel, 1'b1);
        go_to(c + 1);
        set_sig(sel, 1'b0);
    endtask

    task automatic expect_ev(input int code, input int c);
        exp_q.push_back('{code: code, cyc: c});
    endtask

    task automatic sb_pop(input int code);
        ev_t e;
        tests++;
        assert (exp_q.size() != 0) else begin
            fails++;
            $error("FAIL unexpected_pulse: observed code %0d at cycle %0d expected none", code, cyc);
        end
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            assert (e.code == code && e.cyc == cyc) else begin
                fails++;
                $error("FAIL pulse_seq: observed code %0d cycle %0d expected code %0d cycle %0d",
                       code, cyc, e.code, e.cyc);
            end
        end
    endtask

    // Pulse codes: 1 adc_start, 2 park_start, 3 ctrl_en, 4 ipark_start, 5 pwm_load.
    always @(negedge clk) begin
        if (adc_start)   sb_pop(1);
        if (park_start)  sb_pop(2);
        if (ctrl_en)     sb_pop(3);
        if (ipark_start) sb_pop(4);
        if (pwm_load)    sb_pop(5);
        if (adc_start3) begin
            int e3;
            tests++;
            n3++;
            e3 = (exp3.size() != 0) ? exp3.pop_front() : -1;
            assert (e3 == cyc) else begin
                fails++;
                $error("FAIL dec_adc_start: observed cycle %0d expected cycle %0d", cyc, e3);
            end
        end
    end

    task automatic run_best(input string tag);
        int b;
        b = cyc + 2;
        expect_ev(1, b + 1); expect_ev(2, b + 2); expect_ev(3, b + 3);
        expect_ev(4, b + 5); expect_ev(5, b + 6);
        pulse(0, b); pulse(1, b + 1); pulse(2, b + 2); pulse(3, b + 5);
        go_to(b + 7);
        chk({tag, "_loop_cycles"}, loop_cycles, 6);
        chk({tag, "_sb_empty"}, exp_q.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: observed no finish expected finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        int b;
        nrst = 1'b0; run = 1'b0; pwm_sync = 1'b0; adc_done = 1'b0; park_done = 1'b0;
        ipark_done = 1'b0; fault_clr = 1'b0; run3 = 1'b0; sync3 = 1'b0;
        go_to(2);
        chk("rst_outputs", {adc_start, park_start, ctrl_en, ipark_start, pwm_load,
                            busy, timeout_err, overrun_err}, 0);
        chk("rst_loop_cycles", loop_cycles, 0);
        nrst = 1'b1;
        run  = 1'b1;

        // Nominal loop
        b = cyc + 2;
        expect_ev(1, b + 1); expect_ev(2, b + 4); expect_ev(3, b + 6);
        expect_ev(4, b + 8); expect_ev(5, b + 10);
        pulse(0, b); pulse(1, b + 3); pulse(2, b + 5); pulse(3, b + 9);
        go_to(b + 10);
        chk("nom_busy_in_load", busy, 1);
        go_to(b + 11);
        chk("nom_busy_after", busy, 0);
        chk("nom_loop_cycles", loop_cycles, 10);
        chk("nom_sb_empty", exp_q.size(), 0);

        run_best("best");

        // Watchdog expiry in PARK
        b = cyc + 2;
        expect_ev(1, b + 1); expect_ev(2, b + 2);
        pulse(0, b); pulse(1, b + 1);
        go_to(b + 9);
        chk("tmo_flag_before", timeout_err, 0);
        chk("tmo_busy_before", busy, 1);
        go_to(b + 10);
        chk("tmo_flag_set", timeout_err, 1);
        chk("tmo_busy_fault", busy, 0);
        pulse(0, b + 11);
        go_to(b + 13);
        chk("tmo_fault_no_overrun", overrun_err, 0);
        chk("tmo_sb_empty", exp_q.size(), 0);
        pulse(4, b + 13);
        go_to(b + 14);
        chk("tmo_flag_cleared", timeout_err, 0);
        run_best("after_clr");

        // Done in the expiry cycle wins
        b = cyc + 2;
        expect_ev(1, b + 1); expect_ev(2, b + 9); expect_ev(3, b + 10);
        expect_ev(4, b + 12); expect_ev(5, b + 13);
        pulse(0, b); pulse(1, b + 8); pulse(2, b + 9); pulse(3, b + 12);
        go_to(b + 14);
        chk("race_no_timeout", timeout_err, 0);
        chk("race_loop_cycles", loop_cycles, 13);
        chk("race_sb_empty", exp_q.size(), 0);

        // Ticks in IPARK and LOAD
        b = cyc + 2;
        expect_ev(1, b + 1); expect_ev(2, b + 2); expect_ev(3, b + 3);
        expect_ev(4, b + 5); expect_ev(5, b + 7);
        pulse(0, b); pulse(1, b + 1); pulse(2, b + 2); pulse(0, b + 5);
        chk("ovr_set_in_ipark", overrun_err, 1);
        pulse(3, b + 6); pulse(0, b + 7);
        go_to(b + 9);
        chk("ovr_flag", overrun_err, 1);
        chk("ovr_busy_after", busy, 0);
        chk("ovr_loop_cycles", loop_cycles, 7);
        chk("ovr_sb_empty", exp_q.size(), 0);
        pulse(4, b + 10);
        go_to(b + 11);
        chk("ovr_flag_cleared", overrun_err, 0);

        // fault_clr and a new overrun together: the set wins
        b = cyc + 2;
        expect_ev(1, b + 1); expect_ev(2, b + 4); expect_ev(3, b + 5);
        expect_ev(4, b + 7); expect_ev(5, b + 8);
        pulse(0, b);
        go_to(b + 2);
        pwm_sync = 1'b1; fault_clr = 1'b1;
        go_to(b + 3);
        pwm_sync = 1'b0; fault_clr = 1'b0; adc_done = 1'b1;
        go_to(b + 4);
        adc_done = 1'b0;
        chk("prio_set_wins", overrun_err, 1);
        pulse(2, b + 4); pulse(3, b + 7);
        go_to(b + 9);
        chk("prio_loop_cycles", loop_cycles, 8);
        chk("prio_sb_empty", exp_q.size(), 0);

        // run dropped in CTRL
        b = cyc + 2;
        expect_ev(1, b + 1); expect_ev(2, b + 2); expect_ev(3, b + 3);
        pulse(0, b); pulse(1, b + 1); pulse(2, b + 2);
        go_to(b + 4);
        run = 1'b0;
        go_to(b + 5);
        chk("abort_busy", busy, 0);
        chk("abort_loop_cycles", loop_cycles, 8);
        chk("abort_overrun_kept", overrun_err, 1);
        go_to(b + 8);
        chk("abort_sb_empty", exp_q.size(), 0);
        run = 1'b1;

        // Asynchronous reset while in IPARK
        b = cyc + 2;
        expect_ev(1, b + 1); expect_ev(2, b + 2); expect_ev(3, b + 3); expect_ev(4, b + 5);
        pulse(0, b); pulse(1, b + 1); pulse(2, b + 2);
        go_to(b + 6);
        chk("pre_reset_busy", busy, 1);
        #2;
        nrst = 1'b0;
        #1;
        chk("async_rst_outputs", {adc_start, park_start, ctrl_en, ipark_start, pwm_load,
                                  busy, timeout_err, overrun_err}, 0);
        chk("async_rst_loop_cycles", loop_cycles, 0);
        go_to(b + 8);
        nrst = 1'b1;
        chk("rst_sb_empty", exp_q.size(), 0);

        // Decimation by 3 on the second instance
        run3 = 1'b1;
        b = cyc + 2;
        for (int n = 1; n <= 9; n++) begin
            int c;
            c = b + 10 * (n - 1);
            if (n % 3 == 0) exp3.push_back(c + 1);
            go_to(c);
            sync3 = 1'b1;
            go_to(c + 1);
            sync3 = 1'b0;
        end
        go_to(b + 95);
        chk("dec_pulse_count", n3, 3);
        chk("dec_sb_empty", exp3.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/foc_loop_sequencer.md
# foc_loop_sequencer

Per-PWM-period scheduler for the FOC current loop. It decimates the PWM sync pulse, then sequences the stages in order: ADC sampling, Clarke/Park transform, the `current_control` d/q PI update (via its `en`), inverse Park, and PWM duty load. Every wait state has a watchdog, and the block reports overruns and loop latency. It sits between the PWM timer and the current-loop datapath, which does not self-sequence.

## Interface
- `PWM_DIV`, 1: run the loop once every PWM_DIV sync pulses (1..255).
- `CTRL_LAT`, 2: cycles `current_control` needs after its `en` pulse before `v_d`/`v_q` are valid (≥1).
- `TIMEOUT`, 255: maximum cycles to wait for any `*_done` (≥1).
- `CW`, 16: width of `loop_cycles`.

- `clk` in 1: system clock.
- `nrst` in 1: asynchronous, active-low reset.
- `run` in 1: loop enable (level).
- `pwm_sync` in 1: one-cycle pulse per PWM period.
- `adc_start` out 1: one-cycle pulse to start the ADC.
- `adc_done` in 1: ADC sample valid (pulse).
- `park_start` out 1: one-cycle pulse to start Clarke/Park.
- `park_done` in 1: `i_d`/`i_q` valid (pulse).
- `ctrl_en` out 1: one-cycle pulse; drives `current_control.en`.
- `ipark_start` out 1: one-cycle pulse to start inverse Park.
- `ipark_done` in 1: alpha/beta voltages valid (pulse).
- `pwm_load` out 1: one-cycle pulse to latch new duties.
- `busy` out 1: high in any state other than IDLE or FAULT.
- `fault_clr` in 1: leaves FAULT and clears the sticky flags.
- `timeout_err` out 1: sticky; a watchdog expired.
- `overrun_err` out 1: sticky; a tick arrived while busy.
- `loop_cycles` out CW: latency of the last completed loop.

## Operation
- **States:** IDLE, ADC, PARK, CTRL, IPARK, LOAD, FAULT.
- **Tick:** the decimator counts `pwm_sync` pulses and emits `tick` on every PWM_DIV-th pulse. The counter is held at 0 while `run`=0.
- **IDLE → ADC:** on `tick` with `run`=1.
- **ADC → PARK:** on `adc_done`.
- **PARK → CTRL:** on `park_done`.
- **CTRL → IPARK:** after exactly CTRL_LAT cycles in CTRL.
- **IPARK → LOAD:** on `ipark_done`.
- **LOAD → IDLE:** unconditionally, after one cycle.
- **Stage pulses:** each start pulse (`adc_start`, `park_start`, `ctrl_en`, `ipark_start`, `pwm_load`) is registered. It is high only in the first cycle of its state: ADC, PARK, CTRL, IPARK and LOAD respectively.
- **Done sampling:** `*_done` is honoured in any cycle of its wait state, including the start cycle. A `*_done` outside its wait state is ignored.
- **Watchdog:** one counter, cleared on every state entry, counts cycles in ADC, PARK and IPARK. If the count reaches TIMEOUT without the matching done, go to FAULT and set `timeout_err`. A done arriving in the same cycle as expiry wins: the normal transition is taken.
- **FAULT:** all pulses are low. The block stays in FAULT until `fault_clr`, then returns to IDLE.
- **`fault_clr` outside FAULT:** clears both sticky flags only.
- **Overrun:** a `tick` in any busy state, including LOAD, sets `overrun_err`. The tick is dropped and the current sequence continues.
- **`run` deasserted mid-sequence:** abort to IDLE on the next edge. `pwm_load` is not issued and `loop_cycles` is not updated.
- **`loop_cycles`:** counts cycles from the `adc_start` cycle to the `pwm_load` cycle, inclusive. It is latched in LOAD and saturates at 2^CW−1.

## Timing
- **Reset values:** state IDLE, decimator 0, all outputs 0.
- **Tick to start:** `pwm_sync` (with PWM_DIV=1) sampled at edge k gives `adc_start` high during cycle k+1.
- **Stage handoff:** `*_done` high in cycle j gives the next start pulse in cycle j+1.
- **CTRL:** `ctrl_en` in cycle c gives `ipark_start` in cycle c+CTRL_LAT.
- **Best-case loop** (all dones in their start cycle): 4 + CTRL_LAT cycles.
- **Watchdog expiry:** with a start pulse in cycle s and no done, FAULT is entered at cycle s+TIMEOUT and `timeout_err` is high from that cycle.
- **Flag priority:** when `fault_clr` and a new error occur in the same cycle, the set wins.

## Structure
- **Package `foc_pkg`:** holds the `seq_state_t` enum and the PWM_DIV and TIMEOUT counter-width helper constants. It is shared with future outer-loop (speed) sequencing.
- **Sub-module `sync_decimator`:** takes `clk`, `nrst`, `run`, `pwm_sync` and emits `tick`. Parameterised by PWM_DIV.
- **Top level:** the FSM, watchdog and latency counter stay in one module.

## Test plan
- **Nominal loop:** PWM_DIV=1, CTRL_LAT=2; `pwm_sync` at edge 0, `adc_done` in cycle 3, `park_done` in cycle 5, `ipark_done` in cycle 9 → `adc_start`@1, `park_start`@4, `ctrl_en`@6, `ipark_start`@8, `pwm_load`@10, `loop_cycles`=10, `busy` low @11.
- **Decimation:** PWM_DIV=3, 9 `pwm_sync` pulses → exactly 3 `adc_start` pulses, on the 3rd, 6th and 9th sync.
- **Timeout:** TIMEOUT=8, `park_done` never asserted → FAULT 8 cycles after `park_start`, `timeout_err`=1, no `ctrl_en`. `fault_clr` → IDLE, flag cleared, the next tick runs normally.
- **Done-vs-expiry race:** `adc_done` in the same cycle as watchdog expiry → PARK entered, `timeout_err` stays 0.
- **Overrun:** a tick arrives in IPARK and another in LOAD → `overrun_err`=1, the current loop completes with one `pwm_load`, no extra `adc_start`.
- **Abort and reset:** `run` drops in CTRL → IDLE next cycle, no `pwm_load`, `loop_cycles` unchanged. Asserting `nrst` low mid-IPARK → all outputs 0 immediately.
